// File: rtl/md_unit_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer. The Control decoder
// uses the same command codes, so they must stay in step with it.
package md_unit_ctrl_pkg;

  // Command encodings for md_op
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  // Sequencer states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Commands that occupy the unit for a multi-cycle busy window
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Multiplies use the shorter latency
  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_ctrl_md_calc.sv
// Combinational multiply/divide datapath. The result is packed as {hi, lo}:
// products are the full 64-bit value, divides are {remainder, quotient}.
module md_calc
  import md_unit_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;

  // Divisor is forced to 1 when zero so the divider never sees x/0; the
  // result is discarded at commit in that case anyway.
  assign div0    = (b == 32'd0);
  assign divisor = div0 ? 32'd1 : b;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed / and % truncate toward zero, remainder follows the dividend
  assign quot_s = $signed(a) / $signed(divisor);
  assign rem_s  = $signed(a) % $signed(divisor);
  assign quot_u = a / divisor;
  assign rem_u  = a % divisor;

  // Select the packed {hi, lo} result for the command
  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quot_s};
      MD_DIVU:  result = {rem_u, quot_u};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer beside the Execute-stage ALU. Captures the
// result when a command is accepted, holds a busy window for the fixed
// latency, then commits to HI/LO. Also generates the D-stage stall.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [63:0]      pend_reg;
  logic             pend_div0_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;

  logic [63:0]      calc_result;
  logic             calc_div0;
  logic             start_long;
  logic [CNT_W-1:0] start_cnt;

  md_calc u_md_calc (
    .op     (md_op),
    .a      (md_a),
    .b      (md_b),
    .result (calc_result),
    .div0   (calc_div0)
  );

  assign start_long = md_start & is_long_op(md_op);
  assign start_cnt  = is_mult_op(md_op) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

  // Sequencer: accept commands in IDLE, count down in RUN, commit at zero.
  // A start while RUN is ignored; the stall should make it impossible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      pend_reg      <= 64'd0;
      pend_div0_reg <= 1'b0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_long) begin
            pend_reg      <= calc_result;
            pend_div0_reg <= calc_div0 & ~is_mult_op(md_op);
            cnt_reg       <= start_cnt;
            state_reg     <= ST_RUN;
          end else if (md_start && (md_op == MD_MTHI)) begin
            hi_reg <= md_a;
          end else if (md_start && (md_op == MD_MTLO)) begin
            lo_reg <= md_a;
          end
        end
        default: begin
          if (cnt_reg == '0) begin
            if (!pend_div0_reg) begin
              hi_reg <= pend_reg[63:32];
              lo_reg <= pend_reg[31:0];
            end
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
      endcase
    end
  end

  assign busy     = (state_reg == ST_RUN);
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign md_stall = d_md_use & (busy | start_long);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: long operations push their expected
// HI/LO and busy length; the monitor pops and compares when busy falls.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        d_md_use;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  run_len = 0;
  logic busy_prev = 1'b0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .d_md_use (d_md_use),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: stall during busy, no start while busy, scoreboard pop on busy fall
  always @(negedge clk) begin
    if (!reset) begin
      busy_prev = 1'b0;
      run_len   = 0;
    end else begin
      if (md_start) check("start_while_busy", {63'd0, busy}, 64'd0);
      if (busy) begin
        run_len++;
        check("stall_busy", {63'd0, md_stall}, {63'd0, d_md_use});
      end
      if (busy_prev && !busy) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 64'd1, 64'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check($sformatf("%s_lat", e.tag), 64'(run_len), 64'(e.lat));
          check($sformatf("%s_hi", e.tag), {32'd0, hi}, {32'd0, e.hi});
          check($sformatf("%s_lo", e.tag), {32'd0, lo}, {32'd0, e.lo});
          $display("done %s hi=0x%08h lo=0x%08h busy=%0d", e.tag, hi, lo, run_len);
        end
        run_len = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic issue_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input int lat,
                            input string tag);
    wait_idle();
    @(posedge clk); #1;
    md_start = 1'b1; md_op = op; md_a = a; md_b = b;
    sb_q.push_back('{tag, eh, el, lat});
    @(negedge clk);
    check($sformatf("%s_stall_start", tag), {63'd0, md_stall}, {63'd0, d_md_use});
    @(posedge clk); #1;
    md_start = 1'b0; md_op = MD_NONE;
    wait_idle();
  endtask

  task automatic issue_short(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] eh, input logic [31:0] el, input string tag);
    wait_idle();
    @(posedge clk); #1;
    md_start = 1'b1; md_op = op; md_a = a; md_b = $urandom;
    @(negedge clk);
    check($sformatf("%s_stall", tag), {63'd0, md_stall}, 64'd0);
    @(posedge clk); #1;
    md_start = 1'b0; md_op = MD_NONE;
    @(negedge clk);
    check($sformatf("%s_busy", tag), {63'd0, busy}, 64'd0);
    check($sformatf("%s_hi", tag), {32'd0, hi}, {32'd0, eh});
    check($sformatf("%s_lo", tag), {32'd0, lo}, {32'd0, el});
    $display("done %s hi=0x%08h lo=0x%08h", tag, hi, lo);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rp;

    reset = 1'b0; md_start = 1'b0; md_op = MD_NONE;
    md_a = 32'd0; md_b = 32'd0; d_md_use = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("por_busy", {63'd0, busy}, 64'd0);
    check("por_hi", {32'd0, hi}, 64'd0);
    check("por_lo", {32'd0, lo}, 64'd0);
    check("por_stall", {63'd0, md_stall}, 64'd0);

    // MTHI then MULT on the very next cycle
    wait_idle();
    @(posedge clk); #1;
    md_start = 1'b1; md_op = MD_MTHI; md_a = 32'h0000ABCD; md_b = 32'd0;
    @(negedge clk);
    check("mthi_stall", {63'd0, md_stall}, 64'd0);
    @(posedge clk); #1;
    md_op = MD_MULT; md_a = 32'd2; md_b = 32'd3;
    sb_q.push_back('{"mult_b2b", 32'd0, 32'd6, 5});
    @(negedge clk);
    check("mthi_hi", {32'd0, hi}, 64'h0000ABCD);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    md_start = 1'b0; md_op = MD_NONE;
    wait_idle();

    // Multiplies, stall requested from D throughout
    d_md_use = 1'b1;
    issue_long(MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5, "mult_neg");
    issue_long(MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 5, "multu");
    d_md_use = 1'b0;

    // Divides, no D-stage user
    issue_long(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg");
    issue_long(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu");

    // Divide by zero leaves preloaded HI/LO alone
    issue_short(MD_MTHI, 32'h11, 32'h11, 32'd3, "pre_hi");
    issue_short(MD_MTLO, 32'h22, 32'h11, 32'h22, "pre_lo");
    issue_long(MD_DIV, 32'd9, 32'd0, 32'h11, 32'h22, 10, "div0");

    // Command NONE has no effect
    issue_short(MD_NONE, 32'hDEAD, 32'h11, 32'h22, "none");

    // A few random unsigned operations
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 1000);
      rp = {32'd0, ra} * {32'd0, rb};
      d_md_use = i[0];
      issue_long(MD_MULTU, ra, rb, rp[63:32], rp[31:0], 5, $sformatf("rnd_multu%0d", i));
      issue_long(MD_DIVU, ra, rb, ra % rb, ra / rb, 10, $sformatf("rnd_divu%0d", i));
    end
    d_md_use = 1'b0;

    // Asynchronous reset in the middle of a divide
    issue_short(MD_MTHI, 32'h55, 32'h55, ra / rb, "pre_rst");
    @(posedge clk); #1;
    md_start = 1'b1; md_op = MD_DIV; md_a = 32'hFFFFFFF9; md_b = 32'd2;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = MD_NONE;
    @(posedge clk); #2;
    check("rst_pre_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    sb_q.delete();
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_rel_busy", {63'd0, busy}, 64'd0);
    issue_short(MD_MTLO, 32'd5, 32'd0, 32'd5, "mtlo_after_rst");

    repeat (3) @(negedge clk);
    check("sb_left", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL sim_timeout: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
